// File: rtl/decoder_2to4_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decoder_2to4_if                                              |
// | Description : Signal bundle for the registered 2-to-4 decoder. The master  |
// |               drives the enable and binary select. The slave (the decoder) |
// |               returns four one-hot strobes and a valid flag.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   en   master->slave  1  decode enable                                     |
// |   i    master->slave  2  binary select, i[1] is the MSB                    |
// |   y0   slave->master  1  registered select == 2'b00                        |
// |   y1   slave->master  1  registered select == 2'b01                        |
// |   y2   slave->master  1  registered select == 2'b10                        |
// |   y3   slave->master  1  registered select == 2'b11                        |
// |   vld  slave->master  1  y0..y3 hold a decoded value                       |
// +----------------------------------------------------------------------------+
interface decoder_2to4_if;
  logic       en;
  logic [1:0] i;
  logic       y0;
  logic       y1;
  logic       y2;
  logic       y3;
  logic       vld;

  modport master (
    output en,
    output i,
    input  y0,
    input  y1,
    input  y2,
    input  y3,
    input  vld
  );

  modport slave (
    input  en,
    input  i,
    output y0,
    output y1,
    output y2,
    output y3,
    output vld
  );
endinterface
`default_nettype wire

// File: rtl/decoder_2to4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decoder_2to4                                                 |
// | Description : Registered 2-to-4 line decoder. The 2-bit select is turned   |
// |               into a one-hot, active-high 4-line strobe one clock later.   |
// |               A disabled cycle produces all-zero outputs with vld low.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk  in   1  system clock, rising edge                                   |
// |   rst  in   1  synchronous reset, active-high, priority over en and i      |
// |   bus  slave modport of decoder_2to4_if (en, i in; y0..y3, vld out)        |
// +----------------------------------------------------------------------------+
module decoder_2to4 (
  input  wire                 clk,
  input  wire                 rst,
  decoder_2to4_if.slave       bus
);

  localparam logic [3:0] C_Y_NONE = 4'b0000;

  logic [3:0] y_d;
  logic [3:0] y_q;
  logic       vld_d;
  logic       vld_q;

  // Next-state decode. The disabled state is all-zero, not a hold, so there
  // is no feedback from y_q into y_d.
  always_comb begin
    y_d   = C_Y_NONE;
    vld_d = 1'b0;
    if (bus.en) begin
      vld_d = 1'b1;
      case (bus.i)
        2'b00:   y_d = 4'b0001;
        2'b01:   y_d = 4'b0010;
        2'b10:   y_d = 4'b0100;
        2'b11:   y_d = 4'b1000;
        default: y_d = C_Y_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= C_Y_NONE;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  // Outputs come straight from flops: no combinational path from en/i.
  assign bus.y0  = y_q[0];
  assign bus.y1  = y_q[1];
  assign bus.y2  = y_q[2];
  assign bus.y3  = y_q[3];
  assign bus.vld = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_2to4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decoder_2to4                                              |
// | Description : Scoreboard bench for decoder_2to4. Each driven cycle pushes  |
// |               the expected {vld,y3..y0}; the value is popped and compared  |
// |               one edge later. Outputs are also checked to stay stable      |
// |               between edges while inputs move.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decoder_2to4;

  logic clk;
  logic rst;

  decoder_2to4_if bus ();

  decoder_2to4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [4:0] sb_q[$];
  logic [4:0] last_obs;
  logic       have_last;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour written as explicit literals: {vld, y3, y2, y1, y0}.
  function automatic logic [4:0] model(input logic r, input logic e, input logic [1:0] s);
    logic [4:0] res;
    res = 5'b00000;
    if (!r && e) begin
      case (s)
        2'b00: res = 5'b10001;
        2'b01: res = 5'b10010;
        2'b10: res = 5'b10100;
        2'b11: res = 5'b11000;
        default: res = 5'b00000;
      endcase
    end
    return res;
  endfunction

  function automatic logic [4:0] observe();
    return {bus.vld, bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  // Called 1 time unit after a rising edge. Wiggles the inputs, settles
  // them on the real value, checks the outputs did not move, then clocks.
  task automatic step(input logic r, input logic e, input logic [1:0] s, input string tag);
    logic [4:0] obs;
    logic [4:0] exp;
    logic       inv_ok;
    rst    = ~r;
    bus.en = ~e;
    bus.i  = ~s;
    #1;
    rst    = r;
    bus.en = e;
    bus.i  = s;
    sb_q.push_back(model(r, e, s));
    #2;
    if (have_last) chk({tag, "_stable"}, observe(), last_obs);
    @(posedge clk);
    #1;
    obs = observe();
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 5'b00000, 5'b11111);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, obs, exp);
    end
    inv_ok = obs[4] ? $onehot(obs[3:0]) : (obs[3:0] == 4'b0000);
    chk({tag, "_inv"}, {4'b0000, inv_ok}, 5'b00001);
    last_obs  = obs;
    have_last = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    have_last = 1'b0;
    last_obs  = 5'b00000;
    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.i     = 2'b11;
    @(posedge clk);
    #1;

    // Reset with en=1, i=11 for two edges.
    step(1'b1, 1'b1, 2'b11, "reset0");
    step(1'b1, 1'b1, 2'b11, "reset1");

    // Full sweep, each value held 10 cycles.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, v[1:0], "sweep");
    end

    // Latency: 00 then 10; stability check inside step covers "still 0001".
    step(1'b0, 1'b1, 2'b00, "lat_a");
    step(1'b0, 1'b1, 2'b10, "lat_b");

    // Enable gating.
    step(1'b0, 1'b1, 2'b01, "en_on");
    step(1'b0, 1'b0, 2'b01, "en_off");
    step(1'b0, 1'b1, 2'b11, "en_back");

    // Mid-operation reset.
    step(1'b0, 1'b1, 2'b10, "mid_a");
    step(1'b0, 1'b1, 2'b10, "mid_b");
    step(1'b1, 1'b1, 2'b10, "mid_rst");
    step(1'b0, 1'b1, 2'b10, "mid_rel");

    // Random soak.
    for (int n = 0; n < 1000; n++) begin
      logic       rr;
      logic       ee;
      logic [1:0] ss;
      rr = ($urandom_range(0, 19) == 0);
      ee = ($urandom_range(0, 3) != 0);
      ss = 2'($urandom_range(0, 3));
      step(rr, ee, ss, "soak");
    end

    chk("sb_drain", {4'b0000, (sb_q.size() == 0)}, 5'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
